// File: rtl/synth_cfg_loader.sv
// SPI configuration frame loader: oversampled SPI receive, length/CRC check, double-buffered commit on sample_tick.
// Optional CRC-16-CCITT trailer check is enabled by defining CFG_CRC_EN.
module synth_cfg_loader #(
  parameter int FRAME_BITS  = 2048,
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  spi_clk,
  input  logic                  spi_mosi,
  input  logic                  spi_csn,
  input  logic                  sample_tick,
  output logic [FRAME_BITS-1:0] cfg,
  output logic                  cfg_update,
  output logic                  frame_pending,
  output logic [CNT_W-1:0]      len_err_cnt,
  output logic [CNT_W-1:0]      overrun_cnt
`ifdef CFG_CRC_EN
  ,
  output logic [CNT_W-1:0]      crc_err_cnt
`endif
);

`ifdef CFG_CRC_EN
  localparam int EXP_LEN = FRAME_BITS + 16;
`else
  localparam int EXP_LEN = FRAME_BITS;
`endif
  localparam int BC_W = $clog2(EXP_LEN + 2);
  localparam logic [BC_W-1:0] BC_EXP     = BC_W'(EXP_LEN);
  localparam logic [BC_W-1:0] BC_SAT     = BC_W'(EXP_LEN + 1);
  localparam logic [BC_W-1:0] BC_PAYLOAD = BC_W'(FRAME_BITS);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_RECEIVE = 2'd1;
  localparam logic [1:0] ST_CHECK   = 2'd2;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + 1'b1;
  endfunction

  logic [SYNC_STAGES-1:0] sclk_sync, mosi_sync, csn_sync;
  logic                   sclk_prev, csn_prev;
  logic                   sclk_s, mosi_s, csn_s;
  logic                   strobe, csn_fall, csn_rise;

  logic [1:0]             state;
  logic [BC_W-1:0]        bit_cnt;
  logic [FRAME_BITS-1:0]  shift;
  logic [FRAME_BITS-1:0]  hold;
  logic                   bit_en, len_ok, crc_ok, load, commit;

  // Synchronizer stage: raw pins into the clk domain, plus one extra flop for edge detection
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sclk_sync <= '0;
      mosi_sync <= '0;
      csn_sync  <= '0;
      sclk_prev <= 1'b0;
      csn_prev  <= 1'b0;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], spi_clk};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], spi_mosi};
      csn_sync  <= {csn_sync[SYNC_STAGES-2:0], spi_csn};
      sclk_prev <= sclk_sync[SYNC_STAGES-1];
      csn_prev  <= csn_sync[SYNC_STAGES-1];
    end
  end

  assign sclk_s   = sclk_sync[SYNC_STAGES-1];
  assign mosi_s   = mosi_sync[SYNC_STAGES-1];
  assign csn_s    = csn_sync[SYNC_STAGES-1];
  assign strobe   = sclk_s & ~sclk_prev;
  assign csn_fall = csn_prev & ~csn_s;
  assign csn_rise = ~csn_prev & csn_s;
  assign bit_en   = (state == ST_RECEIVE) && strobe && !csn_s;
  assign len_ok   = (bit_cnt == BC_EXP);

`ifdef CFG_CRC_EN
  logic [15:0] crc_calc, crc_rx;

  function automatic logic [15:0] crc_step(input logic [15:0] c, input logic b);
    logic fb;
    fb = c[15] ^ b;
    return {c[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      crc_calc <= '0;
      crc_rx   <= '0;
    end else if (state == ST_IDLE && csn_fall) begin
      crc_calc <= 16'hFFFF;
      crc_rx   <= '0;
    end else if (bit_en) begin
      if (bit_cnt < BC_PAYLOAD)
        crc_calc <= crc_step(crc_calc, mosi_s);
      else if (bit_cnt < BC_EXP)
        crc_rx <= {mosi_s, crc_rx[15:1]};
    end
  end

  assign crc_ok = (crc_calc == crc_rx);
`else
  assign crc_ok = 1'b1;
`endif

  // Receive stage: frame FSM, bit counter and payload shift register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_IDLE;
      bit_cnt <= '0;
      shift   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (csn_fall) begin
            state   <= ST_RECEIVE;
            bit_cnt <= '0;
          end
        end
        ST_RECEIVE: begin
          if (csn_rise) state <= ST_CHECK;
          if (bit_en) begin
            if (bit_cnt != BC_SAT) bit_cnt <= bit_cnt + 1'b1;
            // CRC trailer bits stay out of the payload shift register
            if (bit_cnt < BC_PAYLOAD || EXP_LEN == FRAME_BITS)
              shift <= {mosi_s, shift[FRAME_BITS-1:1]};
          end
        end
        ST_CHECK: state <= ST_IDLE;
        default:  state <= ST_IDLE;
      endcase
    end
  end

  assign load   = (state == ST_CHECK) && len_ok && crc_ok;
  assign commit = sample_tick && frame_pending;

  // Commit stage: hold buffer, active config and error counters
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold          <= '0;
      cfg           <= '0;
      cfg_update    <= 1'b0;
      frame_pending <= 1'b0;
      len_err_cnt   <= '0;
      overrun_cnt   <= '0;
`ifdef CFG_CRC_EN
      crc_err_cnt   <= '0;
`endif
    end else begin
      cfg_update <= commit;
      if (commit) cfg <= hold;
      if (state == ST_CHECK) begin
        if (!len_ok)
          len_err_cnt <= sat_inc(len_err_cnt);
`ifdef CFG_CRC_EN
        else if (!crc_ok)
          crc_err_cnt <= sat_inc(crc_err_cnt);
`endif
        else begin
          hold <= shift;
          // A pending frame drained by a coincident tick was not lost
          if (frame_pending && !commit) overrun_cnt <= sat_inc(overrun_cnt);
        end
      end
      if (load)        frame_pending <= 1'b1;
      else if (commit) frame_pending <= 1'b0;
    end
  end

endmodule

// File: tb/tb_synth_cfg_loader.sv
// Bench for synth_cfg_loader (FRAME_BITS=64): directed and randomized frames against a frame-level reference model.
module tb_synth_cfg_loader;
  localparam int FB = 64;
`ifdef CFG_CRC_EN
  localparam int EXP_LEN = FB + 16;
`else
  localparam int EXP_LEN = FB;
`endif

  logic clk = 1'b0, rst = 1'b1;
  logic spi_clk = 1'b0, spi_mosi = 1'b0, spi_csn = 1'b1, sample_tick = 1'b0;
  logic [FB-1:0] cfg;
  logic cfg_update, frame_pending;
  logic [7:0] len_err_cnt, overrun_cnt;
`ifdef CFG_CRC_EN
  logic [7:0] crc_err_cnt;
`endif

  synth_cfg_loader #(.FRAME_BITS(FB), .SYNC_STAGES(2), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .spi_clk(spi_clk), .spi_mosi(spi_mosi), .spi_csn(spi_csn),
    .sample_tick(sample_tick), .cfg(cfg), .cfg_update(cfg_update),
    .frame_pending(frame_pending), .len_err_cnt(len_err_cnt), .overrun_cnt(overrun_cnt)
`ifdef CFG_CRC_EN
    , .crc_err_cnt(crc_err_cnt)
`endif
  );

  always #5 clk = ~clk;

  int total = 0, bad = 0;

  // Frame-level reference model
  logic [63:0] m_cfg = '0, m_hold = '0;
  bit m_pend = 0, m_upd = 0;
  int m_len = 0, m_ovr = 0, m_crc = 0;
  logic fb_q[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] sat(input int n);
    return (n > 255) ? 64'd255 : 64'(n);
  endfunction

  function automatic logic [15:0] crc16(input logic [63:0] p);
    logic [15:0] c;
    logic f;
    c = 16'hFFFF;
    for (int i = 0; i < 64; i++) begin
      f = c[15] ^ p[i];
      c = {c[14:0], 1'b0};
      if (f) c = c ^ 16'h1021;
    end
    return c;
  endfunction

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic build(input logic [63:0] p, input int nbits, input bit flip);
    logic [15:0] c;
    logic [63:0] q;
    c = crc16(p);
    q = p;
    if (flip) q[5] = ~q[5];
    fb_q.delete();
    for (int i = 0; i < 64; i++) fb_q.push_back(q[i]);
`ifdef CFG_CRC_EN
    for (int i = 0; i < 16; i++) fb_q.push_back(c[i]);
`endif
    while (fb_q.size() < nbits) fb_q.push_back(1'($urandom_range(0, 1)));
    while (fb_q.size() > nbits) void'(fb_q.pop_back());
  endtask

  task automatic shift_out(input int n);
    for (int i = 0; i < n; i++) begin
      spi_mosi = fb_q[i];
      spi_clk = 1'b0;
      wait_clk(4);
      spi_clk = 1'b1;
      wait_clk(4);
    end
    spi_clk = 1'b0;
    wait_clk(4);
  endtask

  task automatic csn_start();
    spi_csn = 1'b0;
    wait_clk(6);
  endtask

  task automatic model_frame(input logic [63:0] p, input int nbits, input bit crc_good);
    if (nbits != EXP_LEN) m_len++;
    else if (!crc_good) m_crc++;
    else begin
      if (m_pend) m_ovr++;
      m_hold = p;
      m_pend = 1;
    end
  endtask

  task automatic model_tick();
    m_upd = m_pend;
    if (m_pend) begin
      m_cfg = m_hold;
      m_pend = 0;
    end
  endtask

  task automatic model_reset();
    m_cfg = '0; m_hold = '0; m_pend = 0; m_upd = 0;
    m_len = 0; m_ovr = 0; m_crc = 0;
  endtask

  task automatic send_frame(input logic [63:0] p, input int nbits, input bit flip);
    build(p, nbits, flip);
    csn_start();
    shift_out(nbits);
    spi_csn = 1'b1;
    wait_clk(8);
    model_frame(p, nbits, !flip);
  endtask

  task automatic check_all(input string tag);
    check({tag, "_cfg"}, cfg, m_cfg);
    check({tag, "_pending"}, 64'(frame_pending), 64'(m_pend));
    check({tag, "_len_err"}, 64'(len_err_cnt), sat(m_len));
    check({tag, "_overrun"}, 64'(overrun_cnt), sat(m_ovr));
`ifdef CFG_CRC_EN
    check({tag, "_crc_err"}, 64'(crc_err_cnt), sat(m_crc));
`endif
  endtask

  task automatic do_tick(input string tag);
    sample_tick = 1'b1;
    wait_clk(1);
    sample_tick = 1'b0;
    model_tick();
    check({tag, "_update"}, 64'(cfg_update), 64'(m_upd));
    check({tag, "_cfg"}, cfg, m_cfg);
    wait_clk(1);
    check({tag, "_update_low"}, 64'(cfg_update), 64'd0);
  endtask

  initial begin
    logic [63:0] pa, pb;
    int nb;

    wait_clk(3);
    check_all("reset");
    check("reset_update", 64'(cfg_update), 64'd0);
    rst = 1'b0;
    wait_clk(4);

    // Basic frame with csn-rise to pending latency
    pa = 64'h0123_4567_89AB_CDEF;
    build(pa, EXP_LEN, 0);
    csn_start();
    shift_out(EXP_LEN);
    spi_csn = 1'b1;
    wait_clk(3);
    check("latency_before", 64'(frame_pending), 64'd0);
    wait_clk(1);
    check("latency_at", 64'(frame_pending), 64'd1);
    model_frame(pa, EXP_LEN, 1);
    wait_clk(96);
    do_tick("t1_tick");
    check("t1_value", cfg, 64'h0123_4567_89AB_CDEF);
    check_all("t1");

    // Short and long frames
    send_frame({$urandom, $urandom}, EXP_LEN - 1, 0);
    send_frame({$urandom, $urandom}, EXP_LEN + 1, 0);
    check("t2_len_err", 64'(len_err_cnt), 64'd2);
    check_all("t2");
    do_tick("t2_tick");

    // Overrun
    send_frame({16{4'h1}}, EXP_LEN, 0);
    send_frame({16{4'h2}}, EXP_LEN, 0);
    check("t3_overrun", 64'(overrun_cnt), 64'd1);
    do_tick("t3_tick");
    check("t3_value", cfg, {16{4'h2}});
    check_all("t3");

    // Reset mid-frame
    build({$urandom, $urandom}, EXP_LEN, 0);
    csn_start();
    shift_out(30);
    rst = 1'b1;
    spi_csn = 1'b1;
    spi_clk = 1'b0;
    wait_clk(2);
    model_reset();
    check_all("t4_in_reset");
    check("t4_in_reset_update", 64'(cfg_update), 64'd0);
    wait_clk(2);
    rst = 1'b0;
    wait_clk(4);
    pa = {$urandom, $urandom};
    send_frame(pa, EXP_LEN, 0);
    do_tick("t4_tick");
    check("t4_value", cfg, pa);
    check_all("t4");

    // Tick coinciding with the CHECK cycle of frame B while A is pending
    pa = {$urandom, $urandom};
    pb = ~pa;
    send_frame(pa, EXP_LEN, 0);
    build(pb, EXP_LEN, 0);
    csn_start();
    shift_out(EXP_LEN);
    spi_csn = 1'b1;
    wait_clk(3);
    sample_tick = 1'b1;
    wait_clk(1);
    sample_tick = 1'b0;
    model_tick();
    model_frame(pb, EXP_LEN, 1);
    check("t5_update", 64'(cfg_update), 64'd1);
    check("t5_cfg_a", cfg, pa);
    check_all("t5_coincide");
    wait_clk(6);
    do_tick("t5_tick2");
    check("t5_cfg_b", cfg, pb);
    check_all("t5");

`ifdef CFG_CRC_EN
    pa = {$urandom, $urandom};
    send_frame(pa, EXP_LEN, 0);
    do_tick("t6_good_tick");
    check("t6_good_value", cfg, pa);
    send_frame({$urandom, $urandom}, EXP_LEN, 1);
    check("t6_crc_err", 64'(crc_err_cnt), 64'd1);
    do_tick("t6_bad_tick");
    check_all("t6");
`endif

    // Randomized frames and tick placement
    for (int k = 0; k < 6; k++) begin
      pa = {$urandom, $urandom};
      nb = ($urandom_range(0, 3) == 0) ? EXP_LEN - 1 - $urandom_range(0, 3) : EXP_LEN;
      send_frame(pa, nb, 0);
      if ($urandom_range(0, 1) == 1) do_tick("rnd_tick");
      check_all("rnd");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
